// File: rtl/tvm_dma_copy_if.sv
// Command, RAM-control and RAM-stream signals of the copy engine.
// The master side is the copy engine; the slave side is the host and RAM that surround it.
interface tvm_dma_copy_if #(
    parameter int WIDTH = 8
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [31:0]       cmd_src_addr;
    logic [31:0]       cmd_dst_addr;
    logic [31:0]       cmd_size;
    logic              busy;
    logic              done;
    logic              ctrl_read_req;
    logic [31:0]       ctrl_read_addr;
    logic [31:0]       ctrl_read_size;
    logic              ctrl_write_req;
    logic [31:0]       ctrl_write_addr;
    logic [31:0]       ctrl_write_size;
    logic [WIDTH-1:0]  mem_read_data;
    logic              mem_read_valid;
    logic              mem_read_dequeue;
    logic [WIDTH-1:0]  mem_write_data;
    logic              mem_write_enable;
    logic              mem_write_full;

    modport master (
        input  cmd_valid, cmd_src_addr, cmd_dst_addr, cmd_size,
        input  mem_read_data, mem_read_valid, mem_write_full,
        output cmd_ready, busy, done,
        output ctrl_read_req, ctrl_read_addr, ctrl_read_size,
        output ctrl_write_req, ctrl_write_addr, ctrl_write_size,
        output mem_read_dequeue, mem_write_data, mem_write_enable
    );

    modport slave (
        output cmd_valid, cmd_src_addr, cmd_dst_addr, cmd_size,
        output mem_read_data, mem_read_valid, mem_write_full,
        input  cmd_ready, busy, done,
        input  ctrl_read_req, ctrl_read_addr, ctrl_read_size,
        input  ctrl_write_req, ctrl_write_addr, ctrl_write_size,
        input  mem_read_dequeue, mem_write_data, mem_write_enable
    );
endinterface

// File: rtl/tvm_dma_copy.sv
// Single-command copy engine: issues one read and one write request to the RAM,
// then streams read words back into the write port through a small FIFO.
module tvm_dma_copy #(
    parameter int WIDTH      = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    tvm_dma_copy_if.master   bus
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, ISSUE, XFER, DONE} state_t;

    state_t           state_reg, state_next;
    logic [31:0]      rd_left_reg, wr_left_reg;
    logic [31:0]      rd_addr_reg, wr_addr_reg, size_reg;
    logic [WIDTH-1:0] fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]      count_reg;

    logic fifo_full, fifo_empty;
    logic accept, push, pop;
    logic cmd_ready, busy, done, issue;

    assign fifo_full  = (count_reg == (AW+1)'(FIFO_DEPTH));
    assign fifo_empty = (count_reg == '0);

    always_comb begin
        state_next = state_reg;
        cmd_ready  = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        issue      = 1'b0;
        accept     = 1'b0;
        push       = 1'b0;
        pop        = 1'b0;
        case (state_reg)
            IDLE: begin
                busy      = 1'b0;
                cmd_ready = 1'b1;
                if (bus.cmd_valid) begin
                    accept     = 1'b1;
                    state_next = (bus.cmd_size == 32'd0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                issue      = 1'b1;
                state_next = XFER;
            end
            XFER: begin
                // Push is judged on this cycle's occupancy, before the pop lands.
                push = bus.mem_read_valid && !fifo_full && (rd_left_reg != 32'd0);
                pop  = !fifo_empty && !bus.mem_write_full && (wr_left_reg != 32'd0);
                if (pop && wr_left_reg == 32'd1)
                    state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            rd_left_reg <= '0;
            wr_left_reg <= '0;
            rd_addr_reg <= '0;
            wr_addr_reg <= '0;
            size_reg    <= '0;
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            count_reg   <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                rd_left_reg <= bus.cmd_size;
                wr_left_reg <= bus.cmd_size;
                // A zero-size copy never issues, so the request outputs keep their old values.
                if (bus.cmd_size != 32'd0) begin
                    rd_addr_reg <= bus.cmd_src_addr;
                    wr_addr_reg <= bus.cmd_dst_addr;
                    size_reg    <= bus.cmd_size;
                end
            end
            if (push) begin
                wr_ptr_reg  <= wr_ptr_reg + 1'b1;
                rd_left_reg <= rd_left_reg - 32'd1;
            end
            if (pop) begin
                rd_ptr_reg  <= rd_ptr_reg + 1'b1;
                wr_left_reg <= wr_left_reg - 32'd1;
            end
            if (push && !pop)
                count_reg <= count_reg + 1'b1;
            else if (pop && !push)
                count_reg <= count_reg - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr_reg] <= bus.mem_read_data;
    end

    assign bus.cmd_ready        = cmd_ready;
    assign bus.busy             = busy;
    assign bus.done             = done;
    assign bus.ctrl_read_req    = issue;
    assign bus.ctrl_write_req   = issue;
    assign bus.ctrl_read_addr   = rd_addr_reg;
    assign bus.ctrl_write_addr  = wr_addr_reg;
    assign bus.ctrl_read_size   = size_reg;
    assign bus.ctrl_write_size  = size_reg;
    assign bus.mem_read_dequeue = push;
    assign bus.mem_write_enable = pop;
    // Masked while empty so stale storage never shows on the write port.
    assign bus.mem_write_data   = fifo_empty ? '0 : fifo_mem[rd_ptr_reg];
endmodule

// File: tb/tb_tvm_dma_copy.sv
// Randomized bench for tvm_dma_copy: a queue-based RAM model feeds the read stream and
// every written word is scored against the words the copy was meant to move.
module tb_tvm_dma_copy;
    localparam int WIDTH      = 8;
    localparam int FIFO_DEPTH = 4;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [WIDTH-1:0] src_q [$];
    logic [WIDTH-1:0] exp_q [$];
    int               stamp_q [$];

    tvm_dma_copy_if #(.WIDTH(WIDTH)) bus ();

    tvm_dma_copy #(.WIDTH(WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_value({tag, "_flags"}, 64'({bus.cmd_ready, bus.busy, bus.done, bus.ctrl_read_req,
                    bus.ctrl_write_req, bus.mem_read_dequeue, bus.mem_write_enable}), 64'b1000000);
        check_value({tag, "_rd_addr"}, 64'(bus.ctrl_read_addr), 64'd0);
        check_value({tag, "_wr_addr"}, 64'(bus.ctrl_write_addr), 64'd0);
        check_value({tag, "_rd_size"}, 64'(bus.ctrl_read_size), 64'd0);
        check_value({tag, "_wr_size"}, 64'(bus.ctrl_write_size), 64'd0);
        check_value({tag, "_wr_data"}, 64'(bus.mem_write_data), 64'd0);
    endtask

    // One copy command. vmode: 0 random valid, 1 always valid, 2 valid on even cycles.
    task automatic run_copy(input string name, input logic [31:0] src, input logic [31:0] dst,
                            input logic [31:0] size, input int base, input int vmode,
                            input int full_pct, input int hold_full, input int extra,
                            input int abort_after, input bit poke);
        int  n_words;
        int  issues = 0, deqs = 0, writes = 0, dones = 0;
        int  issue_k = -1, done_k = -1, first_wr = -1, last_wr = -1;
        int  st;
        bit  finished = 1'b0, aborted = 1'b0, v;
        logic [WIDTH-1:0] w;

        n_words = (size > 32'd64) ? 64 : int'(size);
        src_q.delete();
        exp_q.delete();
        stamp_q.delete();
        for (int i = 0; i < n_words; i++) begin
            w = (base >= 0) ? WIDTH'(base + i) : WIDTH'($urandom);
            src_q.push_back(w);
            exp_q.push_back(w);
        end
        for (int i = 0; i < extra; i++)
            src_q.push_back(WIDTH'($urandom));

        @(negedge clk);
        bus.cmd_valid      = 1'b1;
        bus.cmd_src_addr   = src;
        bus.cmd_dst_addr   = dst;
        bus.cmd_size       = size;
        bus.mem_read_valid = 1'b0;
        bus.mem_write_full = 1'b0;
        bus.mem_read_data  = '0;
        #1;
        check_value({name, "_cmd_ready"}, 64'(bus.cmd_ready), 64'd1);
        @(negedge clk);

        for (int k = 1; k <= 400 && !finished; k++) begin
            bus.cmd_valid = poke && (k == 4);
            if (poke && k == 4)
                bus.cmd_src_addr = src ^ 32'h0000_1000;
            case (vmode)
                1:       v = src_q.size() > 0;
                2:       v = (k % 2 == 0) && (src_q.size() > 0);
                default: v = ($urandom_range(1) == 1) && (src_q.size() > 0);
            endcase
            bus.mem_read_valid = v;
            bus.mem_read_data  = v ? src_q[0] : WIDTH'($urandom);
            bus.mem_write_full = (issue_k > 0 && k <= issue_k + hold_full) ? 1'b1
                                 : (int'($urandom_range(99)) < full_pct);
            #1;
            if (bus.ctrl_read_req || bus.ctrl_write_req) begin
                issues++;
                issue_k = k;
                check_value({name, "_issue_k"}, 64'(k), 64'd1);
                check_value({name, "_reqs"}, 64'({bus.ctrl_read_req, bus.ctrl_write_req}), 64'b11);
                check_value({name, "_rd_addr"}, 64'(bus.ctrl_read_addr), 64'(src));
                check_value({name, "_wr_addr"}, 64'(bus.ctrl_write_addr), 64'(dst));
                check_value({name, "_rd_size"}, 64'(bus.ctrl_read_size), 64'(size));
                check_value({name, "_wr_size"}, 64'(bus.ctrl_write_size), 64'(size));
            end
            if (bus.mem_read_dequeue) begin
                check_value({name, "_deq_valid"}, 64'(v), 64'd1);
                deqs++;
                stamp_q.push_back(k);
                if (src_q.size() > 0)
                    void'(src_q.pop_front());
            end
            if (bus.mem_write_enable) begin
                check_value({name, "_wr_not_full"}, 64'(bus.mem_write_full), 64'd0);
                check_value({name, "_wr_has_word"}, 64'(stamp_q.size() > 0), 64'd1);
                if (stamp_q.size() > 0) begin
                    st = stamp_q.pop_front();
                    check_value({name, "_wr_latency"}, 64'(k > st), 64'd1);
                end
                if (writes < exp_q.size())
                    check_value({name, "_wr_data"}, 64'(bus.mem_write_data), 64'(exp_q[writes]));
                writes++;
                if (first_wr < 0)
                    first_wr = k;
                last_wr = k;
            end
            check_value({name, "_occupancy"}, 64'(stamp_q.size() <= FIFO_DEPTH), 64'd1);
            if (hold_full > 0 && issue_k > 0 && k == issue_k + hold_full)
                check_value({name, "_deq_under_full"}, 64'(deqs),
                            64'((size < FIFO_DEPTH) ? int'(size) : FIFO_DEPTH));
            if (done_k > 0) begin
                check_value({name, "_after_done"}, 64'({bus.busy, bus.cmd_ready, bus.done}), 64'b010);
                finished = 1'b1;
            end else if (bus.done) begin
                dones++;
                done_k = k;
                check_value({name, "_busy_at_done"}, 64'(bus.busy), 64'd1);
                check_value({name, "_done_k"}, 64'(k), 64'((size == 0) ? 1 : last_wr + 1));
            end else begin
                check_value({name, "_busy"}, 64'(bus.busy), 64'd1);
            end
            if (abort_after > 0 && writes == abort_after) begin
                rst                = 1'b1;
                bus.cmd_valid      = 1'b0;
                bus.mem_read_valid = 1'b0;
                bus.mem_write_full = 1'b0;
                @(posedge clk);
                #1;
                check_reset_outputs({name, "_abort"});
                @(negedge clk);
                rst      = 1'b0;
                aborted  = 1'b1;
                finished = 1'b1;
            end
            if (!finished)
                @(negedge clk);
        end

        bus.cmd_valid      = 1'b0;
        bus.mem_read_valid = 1'b0;
        bus.mem_write_full = 1'b0;
        check_value({name, "_complete"}, 64'(finished), 64'd1);
        if (!aborted) begin
            check_value({name, "_issues"}, 64'(issues), 64'((size != 0) ? 1 : 0));
            check_value({name, "_deqs"}, 64'(deqs), 64'(size));
            check_value({name, "_writes"}, 64'(writes), 64'(size));
            check_value({name, "_dones"}, 64'(dones), 64'd1);
            check_value({name, "_leftover"}, 64'(src_q.size()), 64'(extra));
            if (vmode == 1 && full_pct == 0 && hold_full == 0 && size > 1)
                check_value({name, "_streaming"}, 64'(last_wr - first_wr), 64'(size - 1));
        end
        $display("copy %s: src=%h dst=%h size=%0d dequeues=%0d writes=%0d%s",
                 name, src, dst, size, deqs, writes, aborted ? " (reset)" : "");
    endtask

    initial begin
        rst                = 1'b1;
        bus.cmd_valid      = 1'b0;
        bus.cmd_src_addr   = '0;
        bus.cmd_dst_addr   = '0;
        bus.cmd_size       = '0;
        bus.mem_read_data  = '0;
        bus.mem_read_valid = 1'b0;
        bus.mem_write_full = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        run_copy("basic",  32'h10,  32'h80,  32'd4, 'hA1, 1,  0,  0, 0, 0, 1'b0);
        run_copy("zero",   32'h20,  32'h90,  32'd0, -1,   1,  0,  0, 2, 0, 1'b0);
        run_copy("bp",     32'h30,  32'hA0,  32'd8, -1,   1,  0, 10, 0, 0, 1'b0);
        run_copy("sparse", 32'h40,  32'hB0,  32'd5, -1,   2,  0,  0, 1, 0, 1'b0);
        run_copy("abort",  32'h50,  32'hC0,  32'd6, -1,   1,  0,  0, 0, 2, 1'b0);
        run_copy("after",  32'h60,  32'hD0,  32'd2, -1,   1,  0,  0, 1, 0, 1'b0);
        run_copy("poke",   32'h70,  32'hE0,  32'd6, -1,   1,  0,  0, 0, 0, 1'b1);
        run_copy("huge",   32'h100, 32'h200, 32'hFFFF_FFFF, -1, 0, 30, 0, 0, 3, 1'b0);
        for (int i = 0; i < 8; i++)
            run_copy($sformatf("rand%0d", i), $urandom, $urandom,
                     32'($urandom_range(12, 1)), -1, 0, 25, 0, int'($urandom_range(2)), 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
